// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory master: funct3 codes, FSM states
// and byte-lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, SECOND} state_e;

    // Lanes off..off+size-1, clipped to the current word.
    function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [2:0] size);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            m[k] = (k >= int'(off)) && (k < int'(off) + int'(size));
        end
        return m;
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        logic known;
        known = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
        return !known || (we && ((f3 == F3_BU) || (f3 == F3_HU)));
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Request-side and memory-side signals of the LSU master, bundled with
// master (LSU) and slave (pipeline + memory environment) views.
interface lsu_dmem_master_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic [31:0]       load_data;
    logic              load_valid;
    logic              req_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output stall, load_data, load_valid, req_err, mem_we, mem_addr, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  stall, load_data, load_valid, req_err, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: merges data_i into word_i on the masked lanes (store
// path) and extracts/extends the lanes of word_i starting at off_i (load path).
module lsu_align (
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [3:0]  mask_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] merge_o,
    output logic [31:0] ext_o
);
    import lsu_pkg::*;

    logic [31:0] rot_l;
    logic [31:0] rot_r;
    logic [31:0] lanes;

    // Rotation (not shift) lets the same steering serve both halves of a split access.
    always_comb begin
        case (off_i)
            2'd0:    begin rot_l = data_i;                         rot_r = word_i;                         end
            2'd1:    begin rot_l = {data_i[23:0], data_i[31:24]};  rot_r = {word_i[7:0],  word_i[31:8]};   end
            2'd2:    begin rot_l = {data_i[15:0], data_i[31:16]};  rot_r = {word_i[15:0], word_i[31:16]};  end
            default: begin rot_l = {data_i[7:0],  data_i[31:8]};   rot_r = {word_i[23:0], word_i[31:24]};  end
        endcase
    end

    assign lanes   = lane_bits(mask_i);
    assign merge_o = (word_i & ~lanes) | (rot_l & lanes);

    always_comb begin
        case (size_i)
            2'b00:   ext_o = {{24{sign_i & rot_r[7]}},  rot_r[7:0]};
            2'b01:   ext_o = {{16{sign_i & rot_r[15]}}, rot_r[15:0]};
            default: ext_o = rot_r;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// RV32 load/store initiator: converts byte/half/word accesses into word
// accesses, splitting word-crossing ones into two cycles with a stall.
module lsu_dmem_master #(
    parameter int SPLIT_EN = 1,
    parameter int ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    lsu_dmem_master_if.master   bus
);
    import lsu_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] lo_buf_q, lo_buf_d;

    logic [1:0]        off;
    logic [2:0]        size;
    logic [2:0]        end_sum;
    logic [2:0]        hi_size;
    logic              crossing;
    logic              illegal;
    logic [ADDR_W-1:0] word_a;
    logic [3:0]        st_mask;
    logic [31:0]       ld_word;
    logic [31:0]       st_merged;
    logic [31:0]       ld_ext;

    assign off      = bus.req_addr[1:0];
    assign size     = size_of(bus.req_funct3[1:0]);
    assign end_sum  = {1'b0, off} + size;
    assign crossing = end_sum > 3'd4;
    assign hi_size  = end_sum - 3'd4;
    assign illegal  = f3_illegal(bus.req_funct3, bus.req_we);
    assign word_a   = {bus.req_addr[ADDR_W-1:2], 2'b00};

    lsu_align u_store_align (
        .word_i  (bus.mem_rd),
        .data_i  (bus.req_wdata),
        .off_i   (off),
        .mask_i  (st_mask),
        .size_i  (2'b10),
        .sign_i  (1'b0),
        .merge_o (st_merged),
        .ext_o   ()
    );

    lsu_align u_load_align (
        .word_i  (ld_word),
        .data_i  (32'h0),
        .off_i   (off),
        .mask_i  (4'h0),
        .size_i  (bus.req_funct3[1:0]),
        .sign_i  (f3_signed(bus.req_funct3)),
        .merge_o (),
        .ext_o   (ld_ext)
    );

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d        = IDLE;
        lo_buf_d       = '0;
        st_mask        = '0;
        ld_word        = '0;
        bus.stall      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.req_err    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wd     = '0;

        if (!reset && bus.req_valid) begin
            unique case (state_q)
                IDLE: begin
                    bus.mem_addr = word_a;
                    if (illegal) begin
                        bus.req_err    = 1'b1;
                        bus.load_valid = !bus.req_we;
                    end else if (crossing && (SPLIT_EN == 0)) begin
                        bus.req_err    = 1'b1;
                        bus.load_valid = 1'b1;
                    end else begin
                        st_mask = byte_mask(off, size);
                        if (crossing) begin
                            bus.stall = 1'b1;
                            state_d   = SECOND;
                            if (bus.req_we) begin
                                bus.mem_we = 1'b1;
                                bus.mem_wd = st_merged;
                            end else begin
                                lo_buf_d = bus.mem_rd & lane_bits(st_mask);
                            end
                        end else if (bus.req_we) begin
                            bus.mem_we = 1'b1;
                            bus.mem_wd = st_merged;
                        end else begin
                            ld_word        = bus.mem_rd;
                            bus.load_valid = 1'b1;
                            bus.load_data  = ld_ext;
                        end
                    end
                end
                SECOND: begin
                    // Address wraps modulo 2^ADDR_W by plain truncation.
                    bus.mem_addr = word_a + ADDR_W'(4);
                    if (bus.req_we) begin
                        st_mask    = byte_mask(2'd0, hi_size);
                        bus.mem_we = 1'b1;
                        bus.mem_wd = st_merged;
                    end else begin
                        ld_word        = (bus.mem_rd & ~lane_bits(byte_mask(off, size))) | lo_buf_q;
                        bus.load_valid = 1'b1;
                        bus.load_data  = ld_ext;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lo_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_buf_q <= lo_buf_d;
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: one split-enabled DUT and one
// split-disabled DUT, each with its own small word memory.
module tb_lsu_dmem_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    logic prev_stall;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem1 [16];
    logic [31:0] mem0 [16];

    always #5 clk = ~clk;

    lsu_dmem_master_if #(.ADDR_W(32)) b1 ();
    lsu_dmem_master_if #(.ADDR_W(32)) b0 ();

    lsu_dmem_master #(.SPLIT_EN(1), .ADDR_W(32)) u_dut (.clk(clk), .reset(reset), .bus(b1));
    lsu_dmem_master #(.SPLIT_EN(0), .ADDR_W(32)) u_dut_nosplit (.clk(clk), .reset(reset), .bus(b0));

    assign b1.mem_rd = mem1[b1.mem_addr[5:2]];
    assign b0.mem_rd = mem0[b0.mem_addr[5:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 32'h0;
                mem0[i] <= 32'h0;
            end
            mem1[0] <= 32'h44332211;
            mem1[1] <= 32'h88776655;
            mem0[0] <= 32'h44332211;
            mem0[1] <= 32'h88776655;
        end else begin
            if (b1.mem_we) mem1[b1.mem_addr[5:2]] <= b1.mem_wd;
            if (b0.mem_we) mem0[b0.mem_addr[5:2]] <= b0.mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples at the falling edge; a request must be held while stall was high.
    task automatic sample();
        @(negedge clk);
        if (prev_stall) check("proto_hold", b1.req_valid, 1);
        prev_stall = b1.stall;
    endtask

    task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        b1.req_valid  = 1'b1;
        b1.req_we     = we;
        b1.req_funct3 = f3;
        b1.req_addr   = addr;
        b1.req_wdata  = wd;
    endtask

    task automatic idle();
        b1.req_valid  = 1'b0;
        b1.req_we     = 1'b0;
        b1.req_funct3 = 3'b000;
        b1.req_addr   = '0;
        b1.req_wdata  = '0;
    endtask

    task automatic do_preload();
        idle();
        preload = 1'b1;
        tick();
        preload = 1'b0;
    endtask

    logic [2:0]  ld_f3  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] ld_adr [4] = '{32'h7, 32'h7, 32'h2, 32'h6};
    logic [31:0] ld_exp [4] = '{32'hFFFFFF88, 32'h00000088, 32'h00004433, 32'h00008877};

    initial begin
        prev_stall    = 1'b0;
        preload       = 1'b0;
        reset         = 1'b1;
        b0.req_valid  = 1'b0;
        b0.req_we     = 1'b0;
        b0.req_funct3 = 3'b000;
        b0.req_addr   = '0;
        b0.req_wdata  = '0;

        // Reset overrides a valid request
        set_req(1'b0, F3_W, 32'h4, 32'h0);
        sample();
        check("rst_stall", b1.stall, 0);
        check("rst_lv", b1.load_valid, 0);
        check("rst_we", b1.mem_we, 0);
        check("rst_data", b1.load_data, 0);
        check("rst_addr", b1.mem_addr, 0);
        check("rst_err", b1.req_err, 0);
        tick();
        reset = 1'b0;
        do_preload();

        // LW aligned
        set_req(1'b0, F3_W, 32'h0, 32'h0);
        sample();
        check("lw_data", b1.load_data, 32'h44332211);
        check("lw_lv", b1.load_valid, 1);
        check("lw_stall", b1.stall, 0);
        check("lw_we", b1.mem_we, 0);
        tick();

        // Sub-word loads with sign/zero extension
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, ld_f3[i], ld_adr[i], 32'h0);
            sample();
            check($sformatf("ld%0d_data", i), b1.load_data, ld_exp[i]);
            check($sformatf("ld%0d_lv", i), b1.load_valid, 1);
            tick();
        end

        // SB read-modify-write
        set_req(1'b1, F3_B, 32'h1, 32'h000000AB);
        sample();
        check("sb_we", b1.mem_we, 1);
        check("sb_wd", b1.mem_wd, 32'h4433AB11);
        check("sb_stall", b1.stall, 0);
        tick();
        idle();
        check("sb_w0", mem1[0], 32'h4433AB11);
        check("sb_w1", mem1[1], 32'h88776655);
        do_preload();

        // Split LW at 0x2
        set_req(1'b0, F3_W, 32'h2, 32'h0);
        sample();
        check("lw2_stall0", b1.stall, 1);
        check("lw2_addr0", b1.mem_addr, 32'h0);
        check("lw2_lv0", b1.load_valid, 0);
        tick();
        sample();
        check("lw2_stall1", b1.stall, 0);
        check("lw2_addr1", b1.mem_addr, 32'h4);
        check("lw2_lv1", b1.load_valid, 1);
        check("lw2_data", b1.load_data, 32'h66554433);
        tick();

        // Split SW at 0x3
        set_req(1'b1, F3_W, 32'h3, 32'hDDCCBBAA);
        sample();
        check("sw_stall0", b1.stall, 1);
        check("sw_we0", b1.mem_we, 1);
        tick();
        sample();
        check("sw_addr1", b1.mem_addr, 32'h4);
        check("sw_stall1", b1.stall, 0);
        check("sw_we1", b1.mem_we, 1);
        tick();
        idle();
        check("sw_w0", mem1[0], 32'hAA332211);
        check("sw_w1", mem1[1], 32'h88DDCCBB);
        do_preload();

        // Reset during SECOND of split SW drops the high half
        set_req(1'b1, F3_W, 32'h3, 32'hDDCCBBAA);
        sample();
        tick();
        reset = 1'b1;
        sample();
        check("rs_we", b1.mem_we, 0);
        check("rs_lv", b1.load_valid, 0);
        tick();
        reset = 1'b0;
        idle();
        sample();
        check("rs_stall", b1.stall, 0);
        check("rs_w0", mem1[0], 32'hAA332211);
        check("rs_w1", mem1[1], 32'h88776655);
        tick();
        set_req(1'b0, F3_W, 32'h0, 32'h0);
        sample();
        check("rs_lw_addr", b1.mem_addr, 32'h0);
        check("rs_lw_lv", b1.load_valid, 1);
        check("rs_lw_data", b1.load_data, 32'hAA332211);
        tick();

        // Split LW wrapping past the top of the address space
        set_req(1'b0, F3_W, 32'hFFFFFFFE, 32'h0);
        sample();
        check("wrap_addr0", b1.mem_addr, 32'hFFFFFFFC);
        check("wrap_stall0", b1.stall, 1);
        tick();
        sample();
        check("wrap_addr1", b1.mem_addr, 32'h0);
        check("wrap_data", b1.load_data, 32'h22110000);
        tick();

        // Illegal funct3 on a load and on a store
        set_req(1'b0, 3'b011, 32'h0, 32'h0);
        sample();
        check("ill_ld_err", b1.req_err, 1);
        check("ill_ld_lv", b1.load_valid, 1);
        check("ill_ld_data", b1.load_data, 0);
        check("ill_ld_stall", b1.stall, 0);
        tick();
        set_req(1'b1, F3_BU, 32'h0, 32'hFFFFFFFF);
        sample();
        check("ill_st_err", b1.req_err, 1);
        check("ill_st_we", b1.mem_we, 0);
        check("ill_st_lv", b1.load_valid, 0);
        tick();
        idle();

        // Misaligned LH with splitting disabled
        b0.req_valid  = 1'b1;
        b0.req_we     = 1'b0;
        b0.req_funct3 = F3_H;
        b0.req_addr   = 32'hFFFFFFFF;
        sample();
        check("ns_err", b0.req_err, 1);
        check("ns_data", b0.load_data, 0);
        check("ns_lv", b0.load_valid, 1);
        check("ns_stall", b0.stall, 0);
        check("ns_we", b0.mem_we, 0);
        tick();
        b0.req_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Load/store initiator between the MEM pipeline stage and the word-addressed data memory. The memory has a combinational word read and a synchronous word write.
- Converts RV32 byte/halfword/word loads and stores into word-aligned memory accesses.
- Sub-word stores use same-cycle read-modify-write.
- Loads are sign- or zero-extended.
- Accesses that straddle a word boundary are split into two word accesses over two cycles, with a pipeline stall.

Parameters:
SPLIT_EN, 1, 1 = split misaligned word-crossing accesses; 0 = reject them with req_err and perform no memory write.
ADDR_W, 32, byte address width; memory word address is addr[ADDR_W-1:2].

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  MEM-stage access request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU valid for loads only)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  hold pipeline; request must stay stable while high
load_data  out  32  extended load result
load_valid  out  1  load_data valid this cycle
req_err  out  1  illegal funct3, or misaligned access with SPLIT_EN=0
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  word-aligned byte address (bits[1:0]=0)
mem_wd  out  32  memory write data
mem_rd  in  32  memory combinational read data

Behaviour:
- Clocking: single clock domain on clk; reset is synchronous and active-high.
- Reset (and whenever req_valid=0):
  - state=IDLE, lo_buf=0.
  - Outputs: stall=0, load_valid=0, req_err=0, mem_we=0, load_data=0, mem_addr=0, mem_wd=0.
- Size and span:
  - size = 1/2/4 bytes from funct3[1:0].
  - off = addr[1:0]; a request crosses a word when off+size>4.
- Byte order: little-endian; byte k of a word is bits[8k+7:8k].
- Non-crossing access: one cycle, stall=0.
  - mem_addr = {addr[31:2],2'b00}.
  - Load: extract size bytes from mem_rd starting at byte off; sign-extend (B/H) or zero-extend (BU/HU/W); load_valid=1 in the same cycle.
  - Store: mem_wd = mem_rd with bytes off..off+size-1 replaced by the low bytes of req_wdata; mem_we=1. The write commits at the next posedge.
- Crossing access, SPLIT_EN=1, FSM IDLE -> SECOND -> IDLE:
  - Cycle 0 (IDLE): mem_addr = word A = {addr[31:2],00}; stall=1; load_valid=0.
    - Load: latch bytes off..3 of mem_rd into lo_buf.
    - Store: write the merged low part (bytes off..3 from the low bytes of req_wdata), mem_we=1.
    - Next state = SECOND.
  - Cycle 1 (SECOND): mem_addr = A+4, computed modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x0); stall=0.
    - Load: combine lo_buf with bytes 0..(off+size-5) of mem_rd, extend, load_valid=1.
    - Store: merge the remaining high bytes of req_wdata into mem_rd, mem_we=1.
    - Next state = IDLE.
- Crossing access, SPLIT_EN=0: req_err=1, mem_we=0, load_valid=1 with load_data=0, stall=0.
- Illegal funct3 (011, 11x, or 1xx with req_we=1): req_err=1, mem_we=0, load_valid=1 with load_data=0 on loads.
- req_valid dropping while in SECOND is a protocol violation. The FSM still completes SECOND and returns to IDLE; the bench flags it.
- Reset asserted in any state:
  - Next state = IDLE.
  - mem_we=0 in the reset cycle, so the second half of a split store is not written.
  - load_valid=0.
- No back-to-back overlap: a new request is sampled only in IDLE.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum {IDLE, SECOND};
  - function byte_mask(off, size) returning the 4-bit lane mask.
- One natural sub-module: lsu_align, a combinational byte lane extract/merge plus sign extension, instantiated for both the load and store paths.
- FSM and lo_buf live in the top module.

Test Plan:
All scenarios preload memory word 0x0 = 0x44332211 and word 0x4 = 0x88776655.
- LW 0x0 -> load_data=0x44332211, load_valid=1 same cycle, stall=0, mem_we=0.
- LB 0x7 -> 0xFFFFFF88; LBU 0x7 -> 0x00000088; LH 0x2 -> 0x00004433; LHU 0x6 -> 0x00008877.
- SB 0x1, req_wdata=0x000000AB -> one cycle, word 0x0 = 0x4433AB11, word 0x4 unchanged.
- LW 0x2 (SPLIT_EN=1) -> stall=1 for one cycle, mem_addr 0x0 then 0x4, then load_data=0x66554433 with load_valid=1.
- SW 0x3, req_wdata=0xDDCCBBAA -> two cycles, word 0x0 = 0xAA332211, word 0x4 = 0x88DDCCBB.
- Reset asserted in SECOND of SW 0x3 -> word 0x0 = 0xAA332211, word 0x4 stays 0x88776655; next cycle stall=0, state IDLE.
- LH 0xFFFFFFFF with SPLIT_EN=0 -> req_err=1, load_data=0, no stall.
